// File: rtl/adder_pkg.sv
// Shared types for the 4-bit ripple adder result path.
package adder_pkg;

  localparam int SUM_W    = 5;
  localparam int COUT_BIT = 4;

  // Adder result bus: bit 4 = COUT, bits 3..0 = S3..S0.
  typedef logic [SUM_W-1:0] sum_t;

  // Carry-out bit of an adder result.
  function automatic logic sum_cout(input sum_t s);
    return s[COUT_BIT];
  endfunction

endpackage

// File: rtl/adder_sum_collector_if.sv
// Producer/consumer bus of the sum collector: sample input, FIFO output, status.
interface adder_sum_collector_if
  import adder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ACC_W = 12,
  parameter int CNT_W = 8
) ();

  localparam int LVL_W = $clog2(DEPTH) + 1;

  sum_t             sum_in;
  logic             sum_valid;
  logic             clear;
  sum_t             out_data;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] acc_out;
  logic             acc_wrap;
  logic [CNT_W-1:0] drop_cnt;
  logic [LVL_W-1:0] level;

  // Environment side: drives samples, clear and consumer ready.
  modport master (
    output sum_in, sum_valid, clear, out_ready,
    input  out_data, out_valid, acc_out, acc_wrap, drop_cnt, level
  );

  // Collector side.
  modport slave (
    input  sum_in, sum_valid, clear, out_ready,
    output out_data, out_valid, acc_out, acc_wrap, drop_cnt, level
  );

endinterface

// File: rtl/adder_sum_collector_sum_fifo.sv
// First-word-fall-through FIFO of adder results with wrap-bit pointers.
module sum_fifo
  import adder_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  sum_t                     wdata,
  output sum_t                     rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int PW = $clog2(DEPTH);
  typedef logic [PW:0] ptr_t;

  sum_t mem_q [DEPTH];
  sum_t mem_d [DEPTH];
  ptr_t wr_ptr_q, wr_ptr_d;
  ptr_t rd_ptr_q, rd_ptr_d;

  // Next-state for storage and pointers; flush only rewinds the pointers.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q[PW-1:0]] = wdata;
        wr_ptr_d                = wr_ptr_q + ptr_t'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + ptr_t'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
    end
  end

  // State registers; storage is zeroed on reset so the head reads 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      mem_q    <= mem_d;
    end
  end

  // Full: same index, opposite wrap bit. Empty: identical pointers.
  assign full  = (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]) && (wr_ptr_q[PW] != rd_ptr_q[PW]);
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign level = wr_ptr_q - rd_ptr_q;
  assign rdata = mem_q[rd_ptr_q[PW-1:0]];

endmodule

// File: rtl/adder_sum_collector.sv
// Collects adder results: FIFO buffering, wrap-around accumulator, drop counter.
module adder_sum_collector
  import adder_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int ACC_W = 12,
  parameter int CNT_W = 8
) (
  input  logic                  my_clk,
  input  logic                  my_rst,
  adder_sum_collector_if.slave  bus
);

  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             fifo_full;
  logic             fifo_empty;
  logic [LVL_W-1:0] fifo_level;
  sum_t             fifo_head;
  logic             pop;
  logic             push;
  logic             drop;

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W:0]   acc_sum;
  logic             acc_wrap_q, acc_wrap_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // Push/pop/drop decision; clear overrides everything. A full FIFO still
  // accepts a sample when the head leaves in the same cycle.
  always_comb begin
    pop  = 1'b0;
    push = 1'b0;
    drop = 1'b0;
    if (bus.clear) begin
      pop  = 1'b0;
      push = 1'b0;
      drop = 1'b0;
    end else begin
      pop  = !fifo_empty && bus.out_ready;
      push = bus.sum_valid && (!fifo_full || pop);
      drop = bus.sum_valid && fifo_full && !pop;
    end
  end

  // Accumulator, sticky wrap flag and saturating drop counter next-state.
  always_comb begin
    acc_sum    = {1'b0, acc_q} + {{(ACC_W + 1 - SUM_W){1'b0}}, bus.sum_in};
    acc_d      = acc_q;
    acc_wrap_d = acc_wrap_q;
    drop_cnt_d = drop_cnt_q;
    if (bus.clear) begin
      acc_d      = '0;
      acc_wrap_d = 1'b0;
      drop_cnt_d = '0;
    end else begin
      if (push) begin
        acc_d      = acc_sum[ACC_W-1:0];
        acc_wrap_d = acc_wrap_q | acc_sum[ACC_W];
      end else begin
        acc_d      = acc_q;
        acc_wrap_d = acc_wrap_q;
      end
      if (drop && (drop_cnt_q != {CNT_W{1'b1}})) begin
        drop_cnt_d = drop_cnt_q + CNT_W'(1);
      end else begin
        drop_cnt_d = drop_cnt_q;
      end
    end
  end

  // Status registers.
  always_ff @(posedge my_clk or posedge my_rst) begin
    if (my_rst) begin
      acc_q      <= '0;
      acc_wrap_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      acc_q      <= acc_d;
      acc_wrap_q <= acc_wrap_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  sum_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (my_clk),
    .rst   (my_rst),
    .flush (bus.clear),
    .push  (push),
    .pop   (pop),
    .wdata (bus.sum_in),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign bus.out_data  = fifo_head;
  assign bus.out_valid = !fifo_empty;
  assign bus.level     = fifo_level;
  assign bus.acc_out   = acc_q;
  assign bus.acc_wrap  = acc_wrap_q;
  assign bus.drop_cnt  = drop_cnt_q;

endmodule
